rep_detect: RTL

- Repetition detector that sits directly upstream of the multiplier/agrupate chain.
- Accepts one group of GROUP_SIZE activations per transaction and builds a GROUP_SIZE x GROUP_SIZE repetition matrix plus a zero vector.
- Serialises the group into one beat per distinct non-zero value.
- Each beat carries the value, the full matrix and the zero vector in the {zero, rep, value} layout that the downstream agrupate stage expects (after the multiplier widens the value).

---
 rtl/rep_detect_pkg.sv | 35 +++
 rtl/rep_detect_fifo.sv | 70 +++++++
 rtl/rep_detect.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rep_detect_pkg.sv
// rep_detect_pkg: definitions shared by the repetition detector and the
// downstream multiplier/agrupate stages.
//   - beat layout offsets for the {zero, rep, value} word (value in LSBs)
//   - FSM state encoding (IDLE, RUN)
//   - default input FIFO geometry
package rep_detect_pkg;

  // Default geometry of the input group FIFO.
  localparam int DEF_FIFO_SLOTS     = 4;
  localparam int DEF_FIFO_LOG_SLOTS = 2;

  // The value field always starts at bit 0 of a beat.
  localparam int BEAT_VALUE_LSB = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The rep matrix sits directly above the value field.
  function automatic int beat_rep_lsb(input int act_width);
    return BEAT_VALUE_LSB + act_width;
  endfunction

  // The zero vector sits above the GS x GS rep matrix.
  function automatic int beat_zero_lsb(input int act_width, input int group_size);
    return beat_rep_lsb(act_width) + group_size * group_size;
  endfunction

  // Total beat width: value + matrix + zero vector.
  function automatic int beat_width(input int act_width, input int group_size);
    return beat_zero_lsb(act_width, group_size) + group_size;
  endfunction

endpackage

// File: rtl/rep_detect_fifo.sv
// rep_detect_fifo: small synchronous FIFO holding whole activation groups.
//   clk, rst      : clock, synchronous active-low reset (empties the FIFO)
//   wr_en/wr_data : write strobe and data; a write while full is dropped
//   rd_en         : pop the head entry (ignored while empty)
//   rd_data       : head entry, valid whenever empty is low
//   empty/full/almost_full : occupancy flags (almost_full = one slot left)
module rep_detect_fifo
  import rep_detect_pkg::*;
#(
  parameter int NUM_SLOTS     = DEF_FIFO_SLOTS,
  parameter int LOG_NUM_SLOTS = DEF_FIFO_LOG_SLOTS,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full
);

  localparam logic [LOG_NUM_SLOTS:0] FULL_CNT   = (LOG_NUM_SLOTS+1)'(NUM_SLOTS);
  localparam logic [LOG_NUM_SLOTS:0] ALMOST_CNT = (LOG_NUM_SLOTS+1)'(NUM_SLOTS - 1);

  logic [DATA_WIDTH-1:0]    mem_r [NUM_SLOTS];
  logic [LOG_NUM_SLOTS-1:0] wr_ptr_r;
  logic [LOG_NUM_SLOTS-1:0] rd_ptr_r;
  logic [LOG_NUM_SLOTS:0]   count_r;
  logic                     wr_ok_s;
  logic                     rd_ok_s;

  assign empty       = (count_r == {(LOG_NUM_SLOTS+1){1'b0}});
  assign full        = (count_r == FULL_CNT);
  assign almost_full = (count_r == ALMOST_CNT);
  assign wr_ok_s     = wr_en & ~full;
  assign rd_ok_s     = rd_en & ~empty;
  assign rd_data     = mem_r[rd_ptr_r];

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {LOG_NUM_SLOTS{1'b0}};
      rd_ptr_r <= {LOG_NUM_SLOTS{1'b0}};
      count_r  <= {(LOG_NUM_SLOTS+1){1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rep_detect.sv
// rep_detect: repetition detector in front of the multiplier/agrupate chain.
// Each buffered group of GROUP_SIZE activations is decoded into a repetition
// matrix and a zero vector, then serialised as one beat per distinct non-zero
// value (a single value-0 beat for an all-zero group).
//   clk, rst                      : clock, synchronous active-low reset
//   configure, num_iters,
//   num_reads_per_iter            : load run counters and start a run
//   data_in, valid_in, avail_out  : upstream group write port
//   data_out, valid_out, avail_in : downstream beat port {zero, rep, value}
module rep_detect
  import rep_detect_pkg::*;
#(
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_GROUP_SIZE         = 2,
  parameter int ACT_WIDTH              = 8,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  localparam int INPUT_WIDTH  = GROUP_SIZE * ACT_WIDTH,
  localparam int OUTPUT_WIDTH = beat_width(ACT_WIDTH, GROUP_SIZE)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [INPUT_WIDTH-1:0]            data_in,
  input  logic                              valid_in,
  output logic                              avail_out,
  output logic [OUTPUT_WIDTH-1:0]           data_out,
  output logic                              valid_out,
  input  logic                              avail_in
);

  localparam int REP_LSB  = beat_rep_lsb(ACT_WIDTH);
  localparam int ZERO_LSB = beat_zero_lsb(ACT_WIDTH, GROUP_SIZE);
  localparam logic [LOG_MAX_ITERS-1:0]          ITERS_ONE = LOG_MAX_ITERS'(1'b1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READS_ONE = LOG_MAX_READS_PER_ITER'(1'b1);
  localparam logic [GROUP_SIZE-1:0]             GS_ONE    = GROUP_SIZE'(1'b1);

  // FIFO interface
  logic [INPUT_WIDTH-1:0] head_s;
  logic                   empty_s;
  logic                   full_s;
  logic                   almost_full_s;
  logic                   pop_s;

  // Head decode
  logic [ACT_WIDTH-1:0]             act_s [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]            zero_s;
  logic [GROUP_SIZE-1:0]            rep_diag_s;
  logic [GROUP_SIZE*GROUP_SIZE-1:0] rep_s;

  // Selection / emit
  logic [GROUP_SIZE-1:0]     done_mask_r;
  logic [GROUP_SIZE-1:0]     pend_s;
  logic [GROUP_SIZE-1:0]     sel_onehot_s;
  logic [LOG_GROUP_SIZE-1:0] sel_s;
  logic                      last_s;
  logic                      emit_s;
  logic [OUTPUT_WIDTH-1:0]   beat_s;
  logic [OUTPUT_WIDTH-1:0]   data_out_r;
  logic                      valid_out_r;

  // Control
  state_e                            state_r;
  state_e                            state_nx_s;
  logic                              run_s;
  logic                              cfg_load_s;
  logic                              final_group_s;
  logic [LOG_MAX_ITERS-1:0]          iters_r;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_r;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_copy_r;

  rep_detect_fifo #(
    .NUM_SLOTS     (DEF_FIFO_SLOTS),
    .LOG_NUM_SLOTS (DEF_FIFO_LOG_SLOTS),
    .DATA_WIDTH    (INPUT_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (valid_in),
    .wr_data     (data_in),
    .rd_en       (pop_s),
    .rd_data     (head_s),
    .empty       (empty_s),
    .full        (full_s),
    .almost_full (almost_full_s)
  );

  // Keep one slot of slack so a write already in flight still fits.
  assign avail_out = ~full_s & ~almost_full_s;

  // Row r of the matrix is populated only when act[r] is the first
  // occurrence of a non-zero value; it then marks every equal element.
  for (genvar r = 0; r < GROUP_SIZE; r++) begin : g_row
    logic earlier_match_s;

    assign act_s[r]  = head_s[r*ACT_WIDTH +: ACT_WIDTH];
    assign zero_s[r] = (act_s[r] == {ACT_WIDTH{1'b0}});

    // Detect an equal value at a lower index (r is then not a representative).
    always_comb begin
      earlier_match_s = 1'b0;
      for (int c = 0; c < r; c++) begin
        earlier_match_s = earlier_match_s | (act_s[c] == act_s[r]);
      end
    end

    assign rep_diag_s[r] = ~zero_s[r] & ~earlier_match_s;

    for (genvar c = 0; c < GROUP_SIZE; c++) begin : g_col
      assign rep_s[r*GROUP_SIZE + c] = rep_diag_s[r] & (act_s[c] == act_s[r]);
    end
  end

  assign pend_s       = rep_diag_s & ~done_mask_r;
  // Isolate the lowest pending representative (x & -x).
  assign sel_onehot_s = pend_s & (~pend_s + GS_ONE);
  assign last_s       = ~|(pend_s & ~sel_onehot_s);
  assign emit_s       = run_s & ~empty_s & avail_in;
  assign pop_s        = emit_s & last_s;

  // Binary index of the lowest pending representative; scanning downwards
  // lets the lowest index overwrite higher ones. An empty pend selects 0.
  always_comb begin
    sel_s = {LOG_GROUP_SIZE{1'b0}};
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (pend_s[i]) begin
        sel_s = LOG_GROUP_SIZE'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Assemble the {zero, rep, value} beat for the current selection.
  always_comb begin
    beat_s = {OUTPUT_WIDTH{1'b0}};
    beat_s[BEAT_VALUE_LSB +: ACT_WIDTH]     = act_s[sel_s];
    beat_s[REP_LSB +: GROUP_SIZE*GROUP_SIZE] = rep_s;
    beat_s[ZERO_LSB +: GROUP_SIZE]           = zero_s;
  end

  // Output beat register; data_out holds its last value between beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_out_r <= 1'b0;
      data_out_r  <= {OUTPUT_WIDTH{1'b0}};
    end else if (emit_s) begin
      valid_out_r <= 1'b1;
      data_out_r  <= beat_s;
    end else begin
      valid_out_r <= 1'b0;
      data_out_r  <= data_out_r;
    end
  end

  assign valid_out = valid_out_r;
  assign data_out  = data_out_r;

  // Track representatives already emitted for the group at the FIFO head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_mask_r <= {GROUP_SIZE{1'b0}};
    end else if (pop_s) begin
      done_mask_r <= {GROUP_SIZE{1'b0}};
    end else if (emit_s) begin
      done_mask_r <= done_mask_r | sel_onehot_s;
    end else begin
      done_mask_r <= done_mask_r;
    end
  end

  // A configure with either count at zero is ignored.
  assign cfg_load_s    = configure & (num_iters != {LOG_MAX_ITERS{1'b0}})
                         & (num_reads_per_iter != {LOG_MAX_READS_PER_ITER{1'b0}});
  assign final_group_s = pop_s & (reads_r == READS_ONE) & (iters_r == ITERS_ONE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state: a run ends when the last group of the last iteration pops.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_load_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_load_s) begin
          state_nx_s = ST_RUN;
        end else if (final_group_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_RUN:  run_s = 1'b1;
      ST_IDLE: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
  end

  // Run counters: reads_r counts groups left in this iteration, iters_r
  // counts iterations left; reads_copy_r restores reads_r per iteration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iters_r      <= {LOG_MAX_ITERS{1'b0}};
      reads_r      <= {LOG_MAX_READS_PER_ITER{1'b0}};
      reads_copy_r <= {LOG_MAX_READS_PER_ITER{1'b0}};
    end else if (cfg_load_s) begin
      iters_r      <= num_iters;
      reads_r      <= num_reads_per_iter;
      reads_copy_r <= num_reads_per_iter;
    end else if (pop_s) begin
      if (reads_r == READS_ONE) begin
        iters_r <= iters_r - ITERS_ONE;
        if (iters_r == ITERS_ONE) begin
          reads_r <= reads_r - READS_ONE;
        end else begin
          reads_r <= reads_copy_r;
        end
      end else begin
        reads_r <= reads_r - READS_ONE;
      end
    end
  end

endmodule
